// File: rtl/morse_decoder.sv
// Morse key decoder: times key presses against a tick prescaler, classifies
// each press as dot or dash, groups up to four symbols into a character and
// presents it on a valid/ready handshake once the key stays released long
// enough.
module morse_decoder #(
    parameter int TICK_DIV  = 250000,  // clk cycles per timing tick
    parameter int DASH_MIN  = 60,      // press ticks at or above which a symbol is a dash
    parameter int GAP_TICKS = 150      // released ticks that close a character
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic [3:0] sym_code,
    output logic [2:0] sym_len,
    output logic       sym_err,
    output logic       sym_valid,
    input  logic       sym_ready
);

    localparam int PW = (TICK_DIV > 1)  ? $clog2(TICK_DIV)      : 1;
    localparam int CW = (DASH_MIN > 0)  ? $clog2(DASH_MIN + 1)  : 1;
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DASH_LIM   = CW'(DASH_MIN);
    localparam logic [GW-1:0] GAP_LIM    = GW'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        EMIT
    } state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    logic          key_prev_q;
    logic          rise;
    logic          fall;
    logic [CW-1:0] press_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [2:0]    cnt_q;
    logic [3:0]    code_q;
    logic          err_q;
    logic          dash;
    logic [3:0]    sym_code_q;
    logic [2:0]    sym_len_q;
    logic          sym_err_q;
    logic          sym_valid_q;

    assign tick = (presc_q == PRESC_LAST);
    assign rise = key_in & ~key_prev_q;
    assign fall = ~key_in & key_prev_q;
    // The press length is judged on the count before any tick landing on the release edge.
    assign dash = (press_cnt_q >= DASH_LIM);

    // Prescaler next value: wrap to zero on the tick cycle.
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        presc_d = presc_q + 1'b1;
        if (tick) begin
            presc_d = '0;
        end
    end

    // Free-running tick prescaler.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // One-cycle key history for edge detection; reset loads the live level so a
    // key held through reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev_q <= key_in;
        end else begin
            key_prev_q <= key_in;
        end
    end

    // Character assembly FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            err_q       <= 1'b0;
            sym_code_q  <= '0;
            sym_len_q   <= '0;
            sym_err_q   <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q     <= PRESS;
                        press_cnt_q <= '0;
                    end
                end

                PRESS: begin
                    if (fall) begin
                        if (cnt_q < 3'd4) begin
                            code_q[cnt_q[1:0]] <= dash;
                            cnt_q              <= cnt_q + 3'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else if (tick && (press_cnt_q < DASH_LIM)) begin
                        press_cnt_q <= press_cnt_q + 1'b1;
                    end
                end

                GAP: begin
                    // A new press wins over gap expiry in the same cycle.
                    if (rise) begin
                        state_q     <= PRESS;
                        press_cnt_q <= '0;
                    end else if (gap_cnt_q == GAP_LIM) begin
                        state_q     <= EMIT;
                        sym_valid_q <= 1'b1;
                        sym_code_q  <= code_q;
                        sym_len_q   <= cnt_q;
                        sym_err_q   <= err_q;
                    end else if (tick) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                EMIT: begin
                    // Key activity is ignored here; key_prev_q keeps tracking so a
                    // key held across the handshake needs a fresh press.
                    if (sym_valid_q && sym_ready) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        code_q      <= '0;
                        err_q       <= 1'b0;
                        sym_code_q  <= '0;
                        sym_len_q   <= '0;
                        sym_err_q   <= 1'b0;
                        sym_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sym_code  = sym_code_q;
    assign sym_len   = sym_len_q;
    assign sym_err   = sym_err_q;
    assign sym_valid = sym_valid_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder with TICK_DIV=4, DASH_MIN=3, GAP_TICKS=5.
// Stimulus pushes the expected character; the monitor pops and compares on
// every handshake and checks the idle/hold/drop behaviour of the outputs.
module tb_morse_decoder;

    typedef struct packed {
        logic [3:0] code;
        logic [2:0] len;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b0;
    logic       sym_ready = 1'b1;
    logic [3:0] sym_code;
    logic [2:0] sym_len;
    logic       sym_err;
    logic       sym_valid;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_k = 0;
    bit   mon_en = 1'b0;

    morse_decoder #(
        .TICK_DIV (4),
        .DASH_MIN (3),
        .GAP_TICKS(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .sym_code (sym_code),
        .sym_len  (sym_len),
        .sym_err  (sym_err),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready)
    );

    always #5 clk = ~clk;

    // Edge number since reset release; the tick lands on edges divisible by 4.
    always @(posedge clk) begin
        if (rst) edge_k <= 0;
        else     edge_k <= edge_k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the key for exactly t ticks of press time, then release.
    task automatic press(input int t);
        key_in = 1'b1;
        cyc(4 * t + 1);
        key_in = 1'b0;
    endtask

    // Keep the key released for exactly t ticks of gap time.
    task automatic gap(input int t);
        cyc(4 * t + 1);
    endtask

    // Release so that the next rise lands on the cycle the gap counter expires.
    task automatic gap_to_expiry();
        int n = 0;
        cyc(1);
        while (n < 5) begin
            cyc(1);
            if (edge_k % 4 == 0) n++;
        end
    endtask

    task automatic expect_char(input logic [3:0] code, input logic [2:0] len, input logic err);
        exp_t e;
        e.code = code;
        e.len  = len;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            cyc(1);
            n++;
        end
        check({"drain_", name}, sb.size(), 0);
        cyc(2);
    endtask

    // Monitor: compare characters on handshake, check output behaviour each cycle.
    bit         hs_prev = 1'b0;
    bit         valid_prev = 1'b0;
    logic [7:0] out_prev = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (hs_prev) begin
                check("valid_drop", {sym_valid, sym_code, sym_len, sym_err}, 0);
            end else if (!sym_valid) begin
                check("idle_outputs_zero", {sym_code, sym_len, sym_err}, 0);
            end else if (valid_prev) begin
                check("hold_stable", {sym_code, sym_len, sym_err}, {24'd0, out_prev});
            end
            if (sym_valid && sym_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got code=%b len=%0d err=%b with nothing expected",
                             sym_code, sym_len, sym_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sym_code", sym_code, e.code);
                    check("sym_len", sym_len, e.len);
                    check("sym_err", sym_err, e.err);
                end
            end
            hs_prev    = sym_valid && sym_ready;
            valid_prev = sym_valid;
            out_prev   = {sym_code, sym_len, sym_err};
        end
    end

    initial begin
        logic [7:0] held;
        int         n;

        cyc(3);
        mon_en = 1'b1;
        check("reset_valid", sym_valid, 0);
        check("reset_outputs", {sym_code, sym_len, sym_err}, 0);
        rst = 1'b0;
        cyc(2);

        // Dot (2 ticks), gap 2 ticks, dash (4 ticks, saturated)
        expect_char(4'b0010, 3'd2, 1'b0);
        press(2); gap(2); press(4);
        wait_drain("dot_dash");

        // Exactly DASH_MIN ticks is a dash
        expect_char(4'b0001, 3'd1, 1'b0);
        press(3);
        wait_drain("dash_boundary");

        // One tick below DASH_MIN is a dot
        expect_char(4'b0000, 3'd1, 1'b0);
        press(2);
        wait_drain("dot_boundary");

        // Four symbols, no overflow: dash dot dash dash
        expect_char(4'b1101, 3'd4, 1'b0);
        press(3); gap(1); press(1); gap(1); press(3); gap(1); press(4);
        wait_drain("four_symbols");

        // Five dots with 1-tick gaps: fifth dropped, error set
        expect_char(4'b0000, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            press(1); gap(1);
        end
        press(1);
        wait_drain("five_dots");

        // Dash dot dot dot then a dropped dash
        expect_char(4'b0001, 3'd4, 1'b1);
        press(3); gap(1); press(1); gap(1); press(1); gap(1); press(1); gap(1); press(3);
        wait_drain("overflow_dash");

        // Rise in the same cycle as gap expiry continues the character
        expect_char(4'b0010, 3'd2, 1'b0);
        press(1);
        gap_to_expiry();
        press(3);
        wait_drain("rise_beats_expiry");

        // Back-pressure, key activity during EMIT, held key across handshake
        sym_ready = 1'b0;
        expect_char(4'b0001, 3'd2, 1'b0);
        press(3); gap(1); press(1);
        n = 0;
        while (!sym_valid && n < 300) begin
            cyc(1);
            n++;
        end
        check("valid_seen", sym_valid, 1);
        held = {sym_code, sym_len, sym_err};
        for (int i = 0; i < 30; i++) begin
            key_in = (i % 3 != 0) || (i >= 27);
            cyc(1);
        end
        check("held_after_30", {sym_valid, sym_code, sym_len, sym_err}, {23'd0, 1'b1, held});
        sym_ready = 1'b1;
        cyc(1);
        sym_ready = 1'b0;
        check("drop_after_handshake", {sym_valid, sym_code, sym_len, sym_err}, 0);
        cyc(2);
        sym_ready = 1'b1;
        cyc(40);
        key_in = 1'b0;
        cyc(150);
        check("no_char_after_held_key", sym_valid, 0);
        check("sb_empty_after_emit", sb.size(), 0);

        // Reset mid-press with key held: the partial character is discarded
        key_in = 1'b1;
        cyc(10);
        rst = 1'b1;
        cyc(2);
        check("mid_reset_outputs", {sym_valid, sym_code, sym_len, sym_err}, 0);
        rst = 1'b0;
        cyc(20);
        key_in = 1'b0;
        cyc(150);
        check("no_char_after_reset", sym_valid, 0);

        // Fresh press decodes normally after the reset
        expect_char(4'b0000, 3'd1, 1'b0);
        press(2);
        wait_drain("after_reset");

        check("sb_final_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
